// File: rtl/flag_ccr_unit_if.sv
// rtl/flag_ccr_unit_if.sv - execute-stage side bundle of the condition-code register
interface flag_ccr_unit_if #(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 5
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  logic              en;
  logic              flag_wr;
  logic [FLAG_W-1:0] alu_flags;
  logic [2:0]        jmp_type;
  logic              int_save;
  logic              rti;
  logic [FLAG_W-1:0] flags;
  logic              jmp_taken;
  logic [DEPTH_W-1:0] depth;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output en, flag_wr, alu_flags, jmp_type, int_save, rti,
    input  flags, jmp_taken, depth, ovf_err, unf_err
  );

  modport slave (
    input  en, flag_wr, alu_flags, jmp_type, int_save, rti,
    output flags, jmp_taken, depth, ovf_err, unf_err
  );
endinterface

// File: rtl/flag_ccr_unit.sv
// rtl/flag_ccr_unit.sv - condition-code register with jump resolve and interrupt shadow stack
module flag_ccr_unit #(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  flag_ccr_unit_if.slave bus
);
  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

  logic [FLAG_W-1:0]  r_flags;
  logic [FLAG_W-1:0]  r_stack [DEPTH];
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  logic               w_cond;
  logic [FLAG_W-1:0]  w_clr_mask;
  logic               w_jmp_taken;
  logic [FLAG_W-1:0]  w_rule2;
  logic               w_empty;
  logic               w_full;
  logic [IDX_W-1:0]   w_top_idx;
  logic [IDX_W-1:0]   w_push_idx;
  logic [FLAG_W-1:0]  w_next_flags;
  logic [DEPTH_W-1:0] w_next_depth;
  logic               w_next_ovf;
  logic               w_next_unf;
  logic               w_stack_we;
  logic [IDX_W-1:0]   w_stack_widx;

  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == FULL);
  assign w_top_idx  = IDX_W'(r_depth - ONE);
  assign w_push_idx = IDX_W'(r_depth);

  // Resolve the jump against stored flags only and pick the bit a taken conditional clears
  always_comb begin
    w_cond     = 1'b0;
    w_clr_mask = '0;
    case (bus.jmp_type)
      3'b001: begin w_cond = r_flags[0]; w_clr_mask[0] = 1'b1; end
      3'b010: begin w_cond = r_flags[1]; w_clr_mask[1] = 1'b1; end
      3'b011: begin w_cond = r_flags[2]; w_clr_mask[2] = 1'b1; end
      3'b100: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
    w_jmp_taken = bus.en & rst_n & w_cond;
    w_rule2     = (bus.flag_wr ? bus.alu_flags : r_flags) & ~(w_jmp_taken ? w_clr_mask : '0);
  end

  // Next CCR, stack occupancy and error state; a pop (or swap) wins over the ALU write
  always_comb begin
    w_next_flags = r_flags;
    w_next_depth = r_depth;
    w_next_ovf   = r_ovf;
    w_next_unf   = r_unf;
    w_stack_we   = 1'b0;
    w_stack_widx = w_push_idx;
    if (bus.rti && !w_empty) begin
      w_next_flags = r_stack[w_top_idx];
      if (bus.int_save) begin
        w_stack_we   = 1'b1;
        w_stack_widx = w_top_idx;
      end else begin
        w_next_depth = r_depth - ONE;
      end
    end else begin
      w_next_flags = w_rule2;
      if (bus.rti) begin
        w_next_unf = 1'b1;
      end
      if (bus.int_save) begin
        if (w_full) begin
          w_next_ovf = 1'b1;
        end else begin
          w_stack_we   = 1'b1;
          w_next_depth = r_depth + ONE;
        end
      end
    end
  end

  // Register update; stall freezes everything, stack contents are left alone by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (bus.en) begin
      r_flags <= w_next_flags;
      r_depth <= w_next_depth;
      r_ovf   <= w_next_ovf;
      r_unf   <= w_next_unf;
      if (w_stack_we) begin
        r_stack[w_stack_widx] <= r_flags;
      end
    end
  end

  assign bus.flags     = r_flags;
  assign bus.jmp_taken = w_jmp_taken;
  assign bus.depth     = r_depth;
  assign bus.ovf_err   = r_ovf;
  assign bus.unf_err   = r_unf;
endmodule

// File: tb/tb_flag_ccr_unit.sv
// tb/tb_flag_ccr_unit.sv - vector table, corner sequences and random model check for flag_ccr_unit
module tb_flag_ccr_unit;
  localparam int DEPTH  = 4;
  localparam int FLAG_W = 5;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       wr;
    logic [4:0] alu;
    logic [2:0] jt;
    logic       sv;
    logic       rti;
    logic       e_jmp;
    logic [4:0] e_flags;
    logic [2:0] e_depth;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] m_flags;
  logic [4:0] m_q[$];
  logic       m_ovf;
  logic       m_unf;

  vec_t tbl[20];

  flag_ccr_unit_if #(.DEPTH(DEPTH), .FLAG_W(FLAG_W)) bus ();

  flag_ccr_unit #(.DEPTH(DEPTH), .FLAG_W(FLAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic w, input logic [4:0] a,
                              input logic [2:0] j, input logic s, input logic p, input logic ej,
                              input logic [4:0] ef, input logic [2:0] ed, input logic eo,
                              input logic eu);
    vec_t v;
    v.rst_n = r; v.en = e; v.wr = w; v.alu = a; v.jt = j; v.sv = s; v.rti = p;
    v.e_jmp = ej; v.e_flags = ef; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n         = v.rst_n;
    bus.en        = v.en;
    bus.flag_wr   = v.wr;
    bus.alu_flags = v.alu;
    bus.jmp_type  = v.jt;
    bus.int_save  = v.sv;
    bus.rti       = v.rti;
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    #3;
    chk({tag, ".jmp"}, 32'(bus.jmp_taken), 32'(v.e_jmp));
    @(posedge clk);
    #1;
    chk({tag, ".flags"}, 32'(bus.flags), 32'(v.e_flags));
    chk({tag, ".depth"}, 32'(bus.depth), 32'(v.e_depth));
    chk({tag, ".ovf"}, 32'(bus.ovf_err), 32'(v.e_ovf));
    chk({tag, ".unf"}, 32'(bus.unf_err), 32'(v.e_unf));
  endtask

  function automatic logic model_jmp(input vec_t v);
    if (!v.rst_n || !v.en) return 1'b0;
    case (v.jt)
      3'd1: return m_flags[0];
      3'd2: return m_flags[1];
      3'd3: return m_flags[2];
      3'd4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input vec_t v, input logic taken);
    logic [4:0] old;
    logic [4:0] base;
    int n;
    if (!v.rst_n) begin
      m_flags = '0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (!v.en) return;
    old = m_flags;
    n = m_q.size();
    if (v.rti && n > 0) begin
      m_flags = m_q[n-1];
      if (v.sv) m_q[n-1] = old;
      else void'(m_q.pop_back());
    end else begin
      base = v.wr ? v.alu : old;
      if (taken && v.jt >= 3'd1 && v.jt <= 3'd3) base[v.jt - 3'd1] = 1'b0;
      m_flags = base;
      if (v.rti) m_unf = 1'b1;
      if (v.sv) begin
        if (n < DEPTH) m_q.push_back(old);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic t;
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    tbl[0]  = mk(0, 1, 0, 5'h00, 0, 0, 0, 0, 5'h00, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 5'h1f, 4, 1, 0, 0, 5'h00, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 5'h05, 0, 0, 0, 0, 5'h05, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 5'h00, 1, 0, 0, 1, 5'h04, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 5'h00, 2, 0, 0, 0, 5'h04, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 5'h07, 3, 0, 0, 1, 5'h03, 0, 0, 0);
    tbl[6]  = mk(1, 1, 1, 5'h02, 0, 0, 0, 0, 5'h02, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 5'h00, 0, 1, 0, 0, 5'h02, 1, 0, 0);
    tbl[8]  = mk(1, 1, 1, 5'h01, 0, 0, 0, 0, 5'h01, 1, 0, 0);
    tbl[9]  = mk(1, 1, 1, 5'h1f, 0, 0, 1, 0, 5'h02, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 5'h1f, 4, 1, 0, 0, 5'h02, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 5'h18, 4, 0, 1, 1, 5'h18, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 5'h00, 1, 0, 0, 0, 5'h18, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 5'h00, 7, 0, 0, 0, 5'h18, 0, 0, 1);
    tbl[14] = mk(1, 1, 1, 5'h1f, 2, 0, 0, 0, 5'h1f, 0, 0, 1);
    tbl[15] = mk(1, 1, 0, 5'h00, 2, 0, 0, 1, 5'h1d, 0, 0, 1);
    tbl[16] = mk(1, 1, 0, 5'h00, 0, 1, 1, 0, 5'h1d, 1, 0, 1);
    tbl[17] = mk(1, 1, 1, 5'h03, 0, 0, 0, 0, 5'h03, 1, 0, 1);
    tbl[18] = mk(1, 1, 1, 5'h1f, 1, 1, 1, 1, 5'h1d, 1, 0, 1);
    tbl[19] = mk(1, 1, 0, 5'h00, 0, 0, 1, 0, 5'h03, 0, 0, 1);
    for (int i = 0; i < 20; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    apply("ovf.rst", mk(0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0));
    apply("ovf.init", mk(1, 1, 1, 5'h01, 0, 0, 0, 0, 5'h01, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      apply($sformatf("push%0d", k),
            mk(1, 1, 1, 5'(k + 2), 0, 1, 0, 0, 5'(k + 2), 3'((k < 4) ? k + 1 : 4), k == 4, 0));
    for (int k = 0; k < 5; k++)
      apply($sformatf("pop%0d", k),
            mk(1, 1, 0, 0, 0, 0, 1, 0, 5'((k < 4) ? 4 - k : 1), 3'((k < 4) ? 3 - k : 0), 1, k == 4));
    apply("stall.err", mk(1, 0, 1, 5'h1f, 4, 1, 1, 0, 5'h01, 0, 1, 1));

    for (int i = 0; i < 600; i++) begin
      v.rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      v.en    = ($urandom_range(0, 7) != 0);
      v.wr    = 1'($urandom);
      v.alu   = 5'($urandom);
      v.jt    = 3'($urandom_range(0, 7));
      v.sv    = ($urandom_range(0, 2) == 0);
      v.rti   = ($urandom_range(0, 2) == 0);
      drive(v);
      #3;
      t = model_jmp(v);
      chk("rnd.jmp", 32'(bus.jmp_taken), 32'(t));
      model_step(v, t);
      @(posedge clk);
      #1;
      chk("rnd.flags", 32'(bus.flags), 32'(m_flags));
      chk("rnd.depth", 32'(bus.depth), 32'(m_q.size()));
      chk("rnd.ovf", 32'(bus.ovf_err), 32'(m_ovf));
      chk("rnd.unf", 32'(bus.unf_err), 32'(m_unf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_ccr_unit.md
# flag_ccr_unit

Condition-code register (CCR) that sits beside the execute stage. It latches the 5-bit flag vector the ALU produces and feeds the stored value back to the ALU flag input. It also resolves conditional jumps against the stored flags, clears the tested flag when a conditional jump is taken, and saves/restores flags across nested interrupts through a small LIFO stack.

## Interface
- `DEPTH`, default 4: number of shadow-stack entries (nesting depth); must be ≥1.
- `FLAG_W`, default 5: flag vector width. Bit 0 = Z, bit 1 = N, bit 2 = C, bits 3–4 reserved (stored, never tested).

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: pipeline advance; low = stall, all state holds.
- `flag_wr` in 1: load `alu_flags` into CCR this cycle.
- `alu_flags` in FLAG_W: flag vector from ALU output.
- `jmp_type` in 3: 000 none, 001 JZ, 010 JN, 011 JC, 100 JMP (unconditional), others = none.
- `int_save` in 1: push current CCR onto shadow stack.
- `rti` in 1: pop shadow stack into CCR.
- `flags` out FLAG_W: registered CCR, drives ALU flag input.
- `jmp_taken` out 1: combinational jump decision.
- `depth` out $clog2(DEPTH+1): stack occupancy.
- `ovf_err` out 1: sticky, push attempted while full.
- `unf_err` out 1: sticky, pop attempted while empty.

## Operation
- Reset (`rst_n`=0 at edge): `flags`=0, stack pointer=0 (`depth`=0), `ovf_err`=0, `unf_err`=0, stack contents don't-care. Reset overrides `en`.
- `jmp_taken` evaluation uses registered `flags` only; there is no bypass from `alu_flags`. Forwarding hazards are the hazard unit's job.
  - JZ: `flags[0]`. JN: `flags[1]`. JC: `flags[2]`. JMP: 1. None: 0.
  - `jmp_taken` is forced to 0 when `en`=0 or during reset.
- CCR next value, with `en`=1, in priority order:
  1. `rti` with `depth`>0: CCR ← top entry; `flag_wr` and jump-clear are ignored this cycle.
  2. Otherwise, base value is `alu_flags` if `flag_wr`, else `flags`. If the jump is a taken conditional (JZ/JN/JC), the tested bit of the base value is cleared. CCR ← result.
- Stack, with `en`=1:
  - `int_save` pushes the current registered `flags`, i.e. the pre-update value. If `depth`==DEPTH, nothing is pushed and `ovf_err` is set.
  - `rti` with `depth`==0: no pop, CCR follows rule 2, `unf_err` is set.
  - `int_save` and `rti` together: swap. The top entry is replaced by current `flags`, CCR ← old top entry, and `depth` is unchanged. With `depth`==0 this is a plain push: `unf_err` is set, the push succeeds, and CCR follows rule 2.
- Error flags clear only on reset.
- Reserved bits 3–4 are stored and restored verbatim and never cleared by jumps.

## Timing
- `flags`, `depth` and the error flags update 1 cycle after the qualifying edge inputs.
- `jmp_taken` is combinational, with zero latency from `jmp_type`.
- A flag written at edge N is visible to jump evaluation in cycle N+1, and to the ALU `inFlags` in cycle N+1.
- Pushes and pops are single-cycle; back-to-back operations are allowed every cycle.
- `en`=0: no register changes, including error flags and stack.
- `depth` wraps never: it saturates at DEPTH and at 0 via the error rules.

## Test plan
- **Reset and write.** Assert `rst_n`=0 for 2 cycles → `flags`=00000, `depth`=0, errors 0. Then `flag_wr`=1, `alu_flags`=00101 → next cycle `flags`=00101.
- **Taken JZ.** With `flags`=00101: `jmp_type`=001 → `jmp_taken`=1 same cycle; next `flags`=00100. `jmp_type`=010 → `jmp_taken`=0, `flags` unchanged.
- **Jump with simultaneous write.** `flags`=00100, `jmp_type`=011, `flag_wr`=1, `alu_flags`=00111 → `jmp_taken`=1; next `flags`=00011.
- **Save/restore.** `flags`=00010, `int_save` → `depth`=1. `flag_wr` with 00001. `rti` plus `flag_wr` with 11111 same cycle → `flags`=00010, `depth`=0.
- **Overflow/underflow.** With DEPTH=4, 5 consecutive `int_save` → `depth`=4, `ovf_err`=1. Then 5 `rti` → `depth`=0, `unf_err`=1, last `flags`=the first pushed value.
- **Stall.** `en`=0 with `flag_wr`=1, `int_save`=1, `jmp_type`=100 → `jmp_taken`=0; `flags`, `depth` and errors unchanged.
